// File: rtl/aes_pkg.sv
// Shared AES definitions: FIPS-197 forward/inverse S-box tables, SubBytes FSM states, lane helper.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_e;

    localparam int MAX_LANES = 16;

    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] AES_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Words narrower than MAX_LANES are zero-extended by the caller before extraction.
    function automatic logic [7:0] lane_byte(input logic [8*MAX_LANES-1:0] word, input int lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte AES S-box lookup; inv selects the inverse table. Purely combinational.
module aes_sbox_byte (
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);
    import aes_pkg::*;

    assign out_byte = inv ? AES_INV_SBOX[in_byte] : AES_SBOX[in_byte];

endmodule

// File: rtl/aes_subbytes_seq.sv
// Time-multiplexed SubBytes: SBOX_UNITS lookups reused over LANES/SBOX_UNITS cycles.
// IDLE: accepts input | BUSY: one slice per cycle, lowest lanes first | DONE: holds result
module aes_subbytes_seq #(
    parameter int LANES      = 4,
    parameter int SBOX_UNITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);
    import aes_pkg::*;

    localparam int SLICES = LANES / SBOX_UNITS;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SLICES - 1);

    sb_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [8*LANES-1:0] src_q, src_d;
    logic [8*LANES-1:0] res_q, res_d;
    logic               inv_q, inv_d;

    logic                     accept;
    logic                     retire;
    int                       slice_base;
    logic [8*MAX_LANES-1:0]   src_wide;
    logic [7:0]               sb_in  [SBOX_UNITS];
    logic [7:0]               sb_out [SBOX_UNITS];

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
        end
    end

    // Counter holds at its last value instead of wrapping; it is cleared on every accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end else if (retire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slice_base = int'(cnt_q) * SBOX_UNITS;
        src_wide   = '0;
        src_wide[8*LANES-1:0] = src_q;
        for (int u = 0; u < SBOX_UNITS; u++) begin
            sb_in[u] = lane_byte(src_wide, slice_base + u);
        end
    end

    for (genvar g = 0; g < SBOX_UNITS; g++) begin : g_unit
        aes_sbox_byte u_sbox (
            .in_byte  (sb_in[g]),
            .inv      (inv_q),
            .out_byte (sb_out[g])
        );
    end

    always_comb begin
        src_d = src_q;
        inv_d = inv_q;
        res_d = res_q;
        if (accept) begin
            src_d = in_data;
            inv_d = in_inv;
        end
        if (state_q == BUSY) begin
            for (int u = 0; u < SBOX_UNITS; u++) begin
                res_d[8*(slice_base + u) +: 8] = sb_out[u];
            end
        end
    end

    always_comb begin
        in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_data  = res_q;
    end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Directed bench for aes_subbytes_seq in three configurations; S-box reference derived from GF(2^8) math.
module tb_aes_subbytes_seq;

    logic clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_out_data;
    logic        c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_busy;
    logic [31:0] c_in_data, c_out_data;

    int n_cmp;
    int n_err;

    aes_subbytes_seq #(.LANES(4), .SBOX_UNITS(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    aes_subbytes_seq #(.LANES(16), .SBOX_UNITS(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    aes_subbytes_seq #(.LANES(4), .SBOX_UNITS(2)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] fwd_model(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    initial begin
        logic [127:0] bw [4];
        logic [127:0] be [4];
        logic [7:0]   f;

        n_cmp = 0;
        n_err = 0;
        a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_inv = 0; c_in_data = '0; c_out_ready = 0;

        // reset state
        rst = 1'b1;
        negs(2);
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data", a_out_data, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_out_data", b_out_data, 0);
        rst = 1'b0;
        negs(1);
        chk("post_rst_a_in_ready", a_in_ready, 1);
        chk("post_rst_b_in_ready", b_in_ready, 1);

        // 1: forward, LANES=4 SBOX_UNITS=1
        a_in_valid = 1; a_in_inv = 0; a_in_data = 32'hff53_0100;
        negs(1);
        a_in_valid = 0;
        chk("t1_busy_k0", a_busy, 1);
        chk("t1_valid_k0", a_out_valid, 0);
        for (int m = 1; m <= 4; m++) begin
            negs(1);
            chk("t1_busy", a_busy, 1);
            if (m < 4) chk("t1_early_valid", a_out_valid, 0);
            else       chk("t1_valid", a_out_valid, 1);
        end
        chk("t1_data", a_out_data, 32'h16ed_7c63);
        a_out_ready = 1;
        negs(1);
        a_out_ready = 0;
        chk("t1_retired_valid", a_out_valid, 0);
        chk("t1_retired_busy", a_busy, 0);

        // 2: inverse, mode toggled after accept
        a_in_valid = 1; a_in_inv = 1; a_in_data = 32'h16ed_7c63;
        negs(1);
        a_in_valid = 0; a_in_inv = 0;
        negs(4);
        chk("t2_valid", a_out_valid, 1);
        chk("t2_data", a_out_data, 32'hff53_0100);

        // 3: backpressure, then retire+accept in one edge
        a_in_valid = 1; a_in_inv = 0; a_in_data = 32'h0000_0000;
        for (int i = 0; i < 10; i++) begin
            negs(1);
            chk("t3_hold_valid", a_out_valid, 1);
            chk("t3_hold_data", a_out_data, 32'hff53_0100);
            chk("t3_hold_in_ready", a_in_ready, 0);
        end
        a_out_ready = 1;
        #1;
        chk("t3_in_ready_release", a_in_ready, 1);
        negs(1);
        a_in_valid = 0; a_out_ready = 0;
        chk("t3_valid_after_retire", a_out_valid, 0);
        chk("t3_busy_after_accept", a_busy, 1);
        negs(4);
        chk("t3_valid2", a_out_valid, 1);
        chk("t3_data2", a_out_data, 32'h6363_6363);
        a_out_ready = 1;
        negs(1);
        chk("t3_idle", a_busy, 0);

        // 4: LANES=16 single-cycle streaming
        bw[0] = 128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08;
        be[0] = 128'hd4e0b81e_27bfb441_11985d52_aef1e530;
        bw[1] = {16{8'h53}}; be[1] = {16{8'hed}};
        bw[2] = {16{8'h00}}; be[2] = {16{8'h63}};
        bw[3] = {16{8'hff}}; be[3] = {16{8'h16}};
        b_out_ready = 1;
        b_in_valid = 1; b_in_inv = 0; b_in_data = bw[0];
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_in_ready", b_in_ready, 1);
            negs(1);
            chk("t4_busy_valid", b_out_valid, 0);
            chk("t4_busy", b_busy, 1);
            negs(1);
            chk("t4_valid", b_out_valid, 1);
            chk("t4_data", b_out_data, be[i]);
            if (i < 3) b_in_data = bw[i+1];
            else       b_in_valid = 0;
        end
        negs(1);
        chk("t4_end_valid", b_out_valid, 0);
        chk("t4_end_busy", b_busy, 0);

        // 5: reset in BUSY cycle 2
        a_out_ready = 1;
        a_in_valid = 1; a_in_inv = 0; a_in_data = 32'hff53_0100;
        negs(1);
        a_in_valid = 0;
        negs(2);
        rst = 1;
        #1;
        chk("t5_in_ready_in_rst", a_in_ready, 0);
        negs(1);
        chk("t5_rst_valid", a_out_valid, 0);
        chk("t5_rst_data", a_out_data, 0);
        chk("t5_rst_busy", a_busy, 0);
        chk("t5_rst_in_ready", a_in_ready, 0);
        rst = 0;
        negs(1);
        chk("t5_in_ready_after", a_in_ready, 1);
        chk("t5_valid_after", a_out_valid, 0);
        a_in_valid = 1; a_in_inv = 1; a_in_data = 32'h16ed_7c63;
        negs(1);
        a_in_valid = 0;
        negs(4);
        chk("t5_fresh_valid", a_out_valid, 1);
        chk("t5_fresh_data", a_out_data, 32'hff53_0100);

        // 6: exhaustive with LANES=4 SBOX_UNITS=2
        c_out_ready = 1;
        for (int x = 0; x < 256; x++) begin
            f = fwd_model(8'(x));
            c_in_valid = 1; c_in_inv = 0; c_in_data = {4{8'(x)}};
            negs(1);
            c_in_valid = 0;
            negs(2);
            chk("t6_fwd_valid", c_out_valid, 1);
            chk("t6_fwd_data", c_out_data, {4{f}});
            c_in_valid = 1; c_in_inv = 1; c_in_data = {4{f}};
            negs(1);
            c_in_valid = 0;
            negs(2);
            chk("t6_inv_valid", c_out_valid, 1);
            chk("t6_inv_data", c_out_data, {4{8'(x)}});
        end
        negs(1);
        chk("t6_end_valid", c_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
